// File: rtl/i2s_tx_sched_if.sv
// i2s_tx_sched_if: sample-pair handshake and serial stream bundle for i2s_tx_sched
interface i2s_tx_sched_if #(parameter int DATA_W = 32);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;
    logic              enable;
    logic              in_valid;
    logic              WS;
    logic              SD;
    logic              frame_done;
    logic              busy;
    logic [7:0]        underrun_cnt;
    modport master (
        output s_valid, s_left, s_right, enable,
        input  s_ready, in_valid, WS, SD, frame_done, busy, underrun_cnt
    );
    modport slave (
        input  s_valid, s_left, s_right, enable,
        output s_ready, in_valid, WS, SD, frame_done, busy, underrun_cnt
    );
endinterface

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched: buffers stereo pairs in a FIFO and serialises them as back-to-back WS/SD frames
module i2s_tx_sched #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    i2s_tx_sched_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
    state_t            state;
    logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       cnt;
    logic [BW-1:0]     bitcnt;
    logic [DATA_W-1:0] sl, sr;
    logic              v_q, ws_q, sd_q, fd_q;
    logic [7:0]        und_q;
    logic              full, empty, last, push, pop;
    assign full  = cnt == (AW+1)'(FIFO_DEPTH);
    assign empty = cnt == '0;
    assign last  = bitcnt == BW'(DATA_W-1);
    assign push  = bus.s_valid && bus.s_ready;
    // a pop happens only at a frame boundary: from IDLE or on the final right bit
    assign pop   = bus.enable && !empty && (state == IDLE || (state == RIGHT && last));
    assign bus.s_ready      = !rst && !full;
    assign bus.busy         = !rst && (state != IDLE || !empty);
    assign bus.in_valid     = v_q;
    assign bus.WS           = ws_q;
    assign bus.SD           = sd_q;
    assign bus.frame_done   = fd_q;
    assign bus.underrun_cnt = und_q;
    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wp] <= bus.s_left;
            mem_r[wp] <= bus.s_right;
        end
    end
    // state/bitcnt describe the bit currently on SD
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            bitcnt <= '0;
            sl     <= '0;
            sr     <= '0;
            v_q    <= 1'b0;
            ws_q   <= 1'b0;
            sd_q   <= 1'b0;
            fd_q   <= 1'b0;
            und_q  <= '0;
        end else begin
            wp   <= wp + AW'(push);
            rp   <= rp + AW'(pop);
            cnt  <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            fd_q <= state == RIGHT && bitcnt == BW'(DATA_W-2);
            if (pop) begin
                state  <= LEFT;
                bitcnt <= '0;
                sl     <= mem_l[rp] << 1;
                sr     <= mem_r[rp];
                v_q    <= 1'b1;
                ws_q   <= 1'b0;
                sd_q   <= mem_l[rp][DATA_W-1];
            end else if (state == LEFT) begin
                state  <= last ? RIGHT : LEFT;
                bitcnt <= last ? '0 : bitcnt + 1'b1;
                ws_q   <= last;
                sd_q   <= last ? sr[DATA_W-1] : sl[DATA_W-1];
                sl     <= last ? sl : sl << 1;
                sr     <= last ? sr << 1 : sr;
            end else if (state == RIGHT) begin
                if (last) begin
                    state  <= IDLE;
                    bitcnt <= '0;
                    v_q    <= 1'b0;
                    ws_q   <= 1'b0;
                    sd_q   <= 1'b0;
                    if (bus.enable && und_q != 8'hFF) und_q <= und_q + 1'b1;
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                    sd_q   <= sr[DATA_W-1];
                    sr     <= sr << 1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_sched.sv
// tb_i2s_tx_sched: scoreboard bench; pushes queue expected WS/SD/frame_done bits, a monitor checks them
module tb_i2s_tx_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    i2s_tx_sched_if bus ();
    i2s_tx_sched dut (.clk(clk), .rst(rst), .bus(bus));
    logic [2:0] sb [$];
    int n_checks = 0;
    int n_fail   = 0;
    int fd_seen  = 0;
    int run_cur  = 0;
    int last_run = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // monitor: every serial bit must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid) begin
                logic [2:0] e;
                chk("bit_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("stream_bit", 32'({bus.WS, bus.SD, bus.frame_done}), 32'(e));
                end
                run_cur++;
            end else begin
                chk("idle_zero", 32'({bus.WS, bus.SD, bus.frame_done}), 32'd0);
                if (run_cur > 0) last_run = run_cur;
                run_cur = 0;
            end
            if (bus.frame_done) fd_seen++;
        end else run_cur = 0;
    end
    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        int n = 0;
        logic acc;
        bus.s_left  = l;
        bus.s_right = r;
        bus.s_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        chk("push_accept", 32'(acc), 32'd1);
        if (acc) begin
            for (int i = 0; i < 32; i++) sb.push_back({1'b0, l[31-i], 1'b0});
            for (int i = 0; i < 32; i++) sb.push_back({1'b1, r[31-i], i == 31});
        end
    endtask
    task automatic wait_idle(input int lim);
        int n = 0;
        while ((sb.size() != 0 || bus.in_valid) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 32'(n < lim), 32'd1);
        @(posedge clk);
        #1;
    endtask
    task automatic wait_valid(input logic lvl, input int lim);
        int n = 0;
        while (bus.in_valid !== lvl && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_in_valid", 32'(bus.in_valid), 32'(lvl));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        int fd0;
        bus.s_valid = 1'b0;
        bus.s_left  = '0;
        bus.s_right = '0;
        bus.enable  = 1'b0;
        // reset behaviour
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_outs", 32'({bus.in_valid, bus.WS, bus.SD, bus.frame_done, bus.busy,
                                   bus.s_ready, bus.underrun_cnt}), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;
        // single frame, two-cycle latency
        bus.enable = 1'b1;
        fd0 = fd_seen;
        push_pair(32'h8000_0001, 32'hFFFF_0000);
        bus.s_valid = 1'b0;
        chk("latency_t1", 32'(bus.in_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("latency_t2", 32'({bus.in_valid, bus.WS, bus.SD}), 32'b101);
        wait_idle(200);
        chk("single_run", 32'(last_run), 32'd64);
        chk("single_fd", 32'(fd_seen - fd0), 32'd1);
        chk("single_underrun", 32'(bus.underrun_cnt), 32'd1);
        // back-to-back frames
        do_reset();
        fd0 = fd_seen;
        push_pair(32'h1234_5678, 32'h9ABC_DEF0);
        push_pair(32'hA5A5_0F0F, 32'h0000_FFFF);
        push_pair(32'hDEAD_BEEF, 32'hC001_D00D);
        bus.s_valid = 1'b0;
        chk("full_not_ready", 32'(bus.s_ready), 32'd0);
        wait_idle(400);
        chk("b2b_run", 32'(last_run), 32'd192);
        chk("b2b_fd", 32'(fd_seen - fd0), 32'd3);
        chk("b2b_underrun", 32'(bus.underrun_cnt), 32'd1);
        // enable dropped mid-frame
        do_reset();
        fd0 = fd_seen;
        push_pair(32'hF0F0_F0F0, 32'h0F0F_0F0F);
        push_pair(32'h1357_9BDF, 32'h2468_ACE0);
        bus.s_valid = 1'b0;
        wait_valid(1'b1, 10);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        bus.enable = 1'b0;
        wait_valid(1'b0, 100);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("drop_run", 32'(last_run), 32'd64);
        chk("drop_fd", 32'(fd_seen - fd0), 32'd1);
        chk("drop_held", 32'(bus.in_valid), 32'd0);
        chk("drop_busy", 32'(bus.busy), 32'd1);
        chk("drop_underrun", 32'(bus.underrun_cnt), 32'd0);
        chk("drop_pending", 32'(sb.size()), 32'd64);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        chk("resume_start", 32'(bus.in_valid), 32'd1);
        wait_idle(200);
        chk("resume_underrun", 32'(bus.underrun_cnt), 32'd1);
        // reset mid-frame
        do_reset();
        push_pair(32'hCAFE_F00D, 32'h8BAD_F00D);
        bus.s_valid = 1'b0;
        wait_valid(1'b1, 10);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_stop", 32'({bus.in_valid, bus.busy}), 32'd0);
        sb.delete();
        rst = 1'b0;
        #1;
        chk("midrst_empty", 32'({bus.s_ready, bus.busy}), 32'b10);
        repeat (80) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_underrun", 32'(bus.underrun_cnt), 32'd0);
        // saturation of underrun_cnt
        do_reset();
        for (int i = 0; i < 300; i++) begin
            push_pair(32'(i) ^ 32'h5A5A_0000, ~32'(i));
            bus.s_valid = 1'b0;
            wait_idle(200);
            if (i == 253) chk("sat_254", 32'(bus.underrun_cnt), 32'd254);
            if (i == 254) chk("sat_255", 32'(bus.underrun_cnt), 32'd255);
        end
        chk("sat_final", 32'(bus.underrun_cnt), 32'd255);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
